// File: rtl/sequence_generator.sv
// sequence_generator: serial pattern transmitter feeding the 1010 detector link.
// On an accepted start the latched WIDTH-bit pattern is shifted out MSB-first on
// `x`, one bit per clock, repeated repeat_cnt+1 times, followed by a one-cycle
// `done` pulse. All outputs are registered.
//
// Build option: define GAP_BIT_EN to insert one idle cycle (valid=0, x=0)
// between repetitions. Without it, repetitions run back-to-back.
module sequence_generator #(
  parameter int unsigned       WIDTH       = 4,
  parameter logic [WIDTH-1:0]  DEFAULT_PAT = WIDTH'(4'b1010),
  parameter int unsigned       CNT_W       = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern_in,
  input  logic [CNT_W-1:0] repeat_cnt,
  input  logic             abort,
  output logic             x,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
`ifdef GAP_BIT_EN
  localparam logic [1:0] ST_GAP  = 2'd3;
`endif

  logic [1:0]       state;
  logic [WIDTH-1:0] pat_q;     // pattern latched at start, used for reloads
  logic [WIDTH-1:0] shift_q;   // bits still to send, next one at the MSB
  logic [IDX_W-1:0] bit_idx;   // index of the bit currently on x
  logic [CNT_W-1:0] rep_left;  // repetitions still owed after the current one

  logic last_bit;
  logic more_reps;

  // End-of-pattern and repetition-remaining flags
  always_comb begin
    last_bit  = (bit_idx == '0);
    more_reps = (rep_left != '0);
  end

  // Transmit state machine with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      pat_q    <= DEFAULT_PAT;
      shift_q  <= '0;
      bit_idx  <= '0;
      rep_left <= '0;
      x        <= 1'b0;
      valid    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          // abort is meaningless here; start alone decides
          if (start) begin
            pat_q    <= pattern_in;
            rep_left <= repeat_cnt;
            shift_q  <= pattern_in << 1;
            bit_idx  <= LAST_IDX;
            x        <= pattern_in[WIDTH-1];
            valid    <= 1'b1;
            busy     <= 1'b1;
            state    <= ST_SEND;
          end
        end

        ST_SEND: begin
          if (abort) begin
            state <= ST_IDLE;
            x     <= 1'b0;
            valid <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
          end else if (!last_bit) begin
            x       <= shift_q[WIDTH-1];
            shift_q <= shift_q << 1;
            bit_idx <= bit_idx - 1'b1;
          end else if (more_reps) begin
`ifdef GAP_BIT_EN
            state <= ST_GAP;
            x     <= 1'b0;
            valid <= 1'b0;
`else
            x        <= pat_q[WIDTH-1];
            shift_q  <= pat_q << 1;
            bit_idx  <= LAST_IDX;
            rep_left <= rep_left - 1'b1;
`endif
          end else begin
            state <= ST_DONE;
            x     <= 1'b0;
            valid <= 1'b0;
            done  <= 1'b1;
          end
        end

`ifdef GAP_BIT_EN
        ST_GAP: begin
          if (abort) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            x        <= pat_q[WIDTH-1];
            shift_q  <= pat_q << 1;
            bit_idx  <= LAST_IDX;
            rep_left <= rep_left - 1'b1;
            valid    <= 1'b1;
            state    <= ST_SEND;
          end
        end
`endif

        ST_DONE: begin
          // abort here lands in the same place as the normal exit
          state <= ST_IDLE;
          x     <= 1'b0;
          valid <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end

        default: begin
          state <= ST_IDLE;
          x     <= 1'b0;
          valid <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sequence_generator.sv
// Scoreboard bench for sequence_generator. The driver computes each transfer's
// expected bit stream from the pattern/repeat rules and queues it; a monitor
// pops one entry whenever the DUT shows valid or done. Cycle timing of valid,
// busy and done is checked by the driver against a timeline it computes itself.
module tb_sequence_generator;
  localparam int unsigned WIDTH = 4;
  localparam int unsigned CNT_W = 4;
`ifdef GAP_BIT_EN
  localparam bit GAP = 1'b1;
`else
  localparam bit GAP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [WIDTH-1:0] pattern_in = '0;
  logic [CNT_W-1:0] repeat_cnt = '0;
  logic             x, valid, busy, done;

  int checks = 0;
  int failures = 0;
  // entries are {valid, done, x}
  logic [2:0] exp_q[$];

  sequence_generator #(
    .WIDTH(WIDTH),
    .DEFAULT_PAT(4'b1010),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .pattern_in(pattern_in),
    .repeat_cnt(repeat_cnt),
    .abort(abort),
    .x(x),
    .valid(valid),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle (counted from the accepting edge) on which stream bit i appears
  function automatic int bit_cycle(input int i);
    return 1 + i + (GAP ? i / WIDTH : 0);
  endfunction

  function automatic int done_cycle(input int r);
    return WIDTH * (r + 1) + (GAP ? r : 0) + 1;
  endfunction

  function automatic bit is_bit_cycle(input int j, input int r);
    for (int i = 0; i < WIDTH * (r + 1); i++)
      if (bit_cycle(i) == j) return 1'b1;
    return 1'b0;
  endfunction

  // Queue every output shown up to and including cycle `stop`
  task automatic push_expected(input logic [WIDTH-1:0] p, input int r, input int stop);
    logic b;
    for (int i = 0; i < WIDTH * (r + 1); i++) begin
      if (bit_cycle(i) <= stop) begin
        b = p[WIDTH-1-(i % WIDTH)];
        exp_q.push_back({2'b10, b});
      end
    end
    if (stop >= done_cycle(r)) exp_q.push_back(3'b010);
  endtask

  // Monitor: pop and compare whenever the DUT presents an output
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid || done) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output: got valid=%0b done=%0b x=%0b expected no output at %0t",
                   valid, done, x, $time);
        end else begin
          check("stream", {29'b0, valid, done, x}, {29'b0, exp_q.pop_front()});
        end
      end
      if (!valid) check("x_zero_when_invalid", {31'b0, x}, 32'd0);
    end
  end

  // One transfer. abort_at > 0 raises abort during that cycle after the start edge.
  task automatic run_txn(input logic [WIDTH-1:0] p, input logic [CNT_W-1:0] r,
                         input bit hold, input int abort_at);
    int d, stop;
    d = done_cycle(int'(r));
    stop = (abort_at > 0 && abort_at <= d) ? abort_at : d;
    @(negedge clk);
    check("idle_busy", {31'b0, busy}, 32'd0);
    check("idle_valid", {31'b0, valid}, 32'd0);
    push_expected(p, int'(r), stop);
    start = 1'b1;
    pattern_in = p;
    repeat_cnt = r;
    abort = 1'($urandom_range(0, 1));
    for (int j = 1; j <= stop; j++) begin
      @(negedge clk);
      check("busy_timing", {31'b0, busy}, 32'd1);
      check("valid_timing", {31'b0, valid}, {31'b0, is_bit_cycle(j, int'(r))});
      check("done_timing", {31'b0, done}, {31'b0, (j == d)});
      start = hold;
      abort = (abort_at > 0 && j == stop);
      pattern_in = WIDTH'($urandom);
      repeat_cnt = CNT_W'($urandom);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      start = 1'b0;
      abort = 1'($urandom_range(0, 1));
      check("idle_gap_busy", {31'b0, busy}, 32'd0);
    end
  endtask

  // Asynchronous reset between clock edges partway through a transfer
  task automatic reset_mid(input logic [WIDTH-1:0] p, input logic [CNT_W-1:0] r, input int k);
    @(negedge clk);
    push_expected(p, int'(r), done_cycle(int'(r)));
    start = 1'b1;
    pattern_in = p;
    repeat_cnt = r;
    abort = 1'b0;
    for (int j = 0; j < k; j++) begin
      @(negedge clk);
      start = 1'b0;
    end
    @(posedge clk);
    #2;
    check("pre_reset_valid", {31'b0, valid}, 32'd1);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("async_rst_x", {31'b0, x}, 32'd0);
    check("async_rst_valid", {31'b0, valid}, 32'd0);
    check("async_rst_busy", {31'b0, busy}, 32'd0);
    check("async_rst_done", {31'b0, done}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, ab;
    repeat (2) @(negedge clk);
    check("reset_x", {31'b0, x}, 32'd0);
    check("reset_valid", {31'b0, valid}, 32'd0);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    rst_n = 1'b1;

    run_txn(4'b1010, 4'd0, 1'b0, 0);
    run_txn(4'b1010, 4'd2, 1'b0, 0);
    run_txn(4'b0110, 4'd0, 1'b1, 0);
    run_txn(4'b0110, 4'd0, 1'b0, 0);
    run_txn(4'b1101, 4'd3, 1'b0, 2);
    run_txn(4'b1001, 4'd0, 1'b0, 0);
    run_txn(4'b1010, 4'd1, 1'b0, 0);
    run_txn(4'b1111, 4'd15, 1'b1, 0);
    run_txn(4'b0011, 4'd1, 1'b0, done_cycle(1));
    idle_cycles(2);
    reset_mid(4'b1100, 4'd1, 2);
    run_txn(4'b1011, 4'd1, 1'b0, 0);

    for (int t = 0; t < 40; t++) begin
      r = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 3));
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, done_cycle(r))) : 0;
      run_txn(WIDTH'($urandom), CNT_W'(r), 1'($urandom_range(0, 1)), ab);
      idle_cycles(int'($urandom_range(0, 2)));
    end

    idle_cycles(3);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sequence_generator.md
Name: sequence_generator

Overview:
Serial pattern transmitter: the other end of the serial 1010 detector link. On a start request it shifts a latched WIDTH-bit pattern out MSB-first on `x`, one bit per clock. It can send the pattern repeatedly back-to-back, so an overlapping Mealy detector downstream can be exercised. It sits upstream of the detector (`x` wires straight to the detector's `x`) as a stimulus/link source.

Parameters:
WIDTH, 4, pattern length in bits (>=2)
DEFAULT_PAT, 4'b1010, pattern driven onto `pattern_in` by benches that want the detector sequence
CNT_W, 4, width of repeat count

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  reset, asynchronous, active-low
start  input  1  request transmission; sampled only in IDLE
pattern_in  input  WIDTH  pattern to send; latched on accepted start
repeat_cnt  input  CNT_W  extra repetitions; total sends = repeat_cnt+1; latched on accepted start
abort  input  1  synchronous stop
x  output  1  serial data bit
valid  output  1  high when `x` carries a pattern bit
busy  output  1  high from accepted start until return to IDLE
done  output  1  one-cycle pulse after the final bit of the final repetition

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; x=0, valid=0, busy=0, done=0; shift register, bit counter and repeat counter cleared. Reset mid-transmission discards the transfer immediately; no `done` is produced.
- All outputs are registered. `x` is 0 whenever `valid`=0.
- IDLE:
  - start=1 at an edge: latch pattern_in and repeat_cnt, go to SEND, busy=1.
  - The first bit (pattern MSB) appears on `x` with valid=1 in the cycle after the accepting edge. Latency is 1 clock.
- SEND:
  - One bit per cycle, MSB to LSB. Bit index runs WIDTH-1 down to 0.
  - At index 0 with repetitions remaining: reload the shift register from the latched pattern, decrement the repeat counter, and continue in the next cycle with no gap. `valid` stays high continuously.
  - At index 0 with no repetitions remaining: go to DONE.
- DONE: one cycle with done=1, valid=0, x=0, busy=1. Then IDLE, where busy=0.
- start is ignored while busy, including in DONE. A new start is accepted at the earliest in the cycle after DONE. Changes to pattern_in and repeat_cnt during busy have no effect.
- abort=1 in SEND or DONE: next cycle state=IDLE, valid=0, x=0, busy=0, done=0. The abort cycle's own outputs are unaffected. abort has priority over a repeat reload. abort is ignored in IDLE. If start and abort are both high in IDLE, start wins.
- Total valid bits per transfer = WIDTH*(repeat_cnt+1), for example 2^CNT_W*WIDTH at maximum. Counters must not wrap inside a transfer.

Optional Feature:
GAP_BIT_EN:
- Defined: between repetitions, state GAP inserts one cycle with valid=0, x=0 before the reload. The first bit of each later repetition is delayed by one cycle. No gap follows the final repetition; DONE follows directly. abort in GAP behaves as in SEND.
- Undefined: repetitions are back-to-back, as described above.

Test Plan:
1. Reset, then start with pattern_in=4'b1010, repeat_cnt=0 -> x=1,0,1,0 with valid=1 on cycles 1-4 after the start edge; done=1 on cycle 5; busy=0 on cycle 6.
2. pattern_in=1010, repeat_cnt=2, x wired to the 1010 Mealy detector -> 12 valid bits 101010101010. Detector y pulses 5 times, at bits 4, 6, 8, 10 and 12. One done pulse.
3. pattern_in=4'b0110 with start held high through busy -> only one transfer (0,1,1,0, then done). A second transfer starts the cycle after IDLE is re-entered.
4. abort asserted on the 2nd bit of a repeat_cnt=3 transfer -> next cycle valid=0, x=0, busy=0. No done pulse. A fresh start is accepted after that.
5. rst_n driven low asynchronously mid-bit, between clock edges -> x, valid, busy and done drop to 0 immediately. After release, a start gives a clean transfer from the MSB.
6. GAP_BIT_EN defined, pattern 1010, repeat_cnt=1 -> x/valid sequence 1,0,1,0,(gap: valid=0),1,0,1,0, then done. Detector y pulses at bits 4 and 9 only.
